// File: rtl/systolic_nxn_sparse_if.sv
// Operand-stream and result-tile bundle for the N x N sparse systolic tile.
// The master drives operand beats and takes results; the slave is the array.
interface systolic_nxn_sparse_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int AW = 20,
   parameter int CW = 16
);
   logic                in_valid;
   logic                in_ready;
   logic                in_last;
   logic [N*DW-1:0]     a_vec;
   logic [N*DW-1:0]     b_vec;
   logic                out_valid;
   logic                out_ready;
   logic [N*N*AW-1:0]   c_flat;
   logic [CW-1:0]       skip_cnt;
   logic                busy;

   modport master (
      output in_valid, in_last, a_vec, b_vec, out_ready,
      input  in_ready, out_valid, c_flat, skip_cnt, busy
   );

   modport slave (
      input  in_valid, in_last, a_vec, b_vec, out_ready,
      output in_ready, out_valid, c_flat, skip_cnt, busy
   );
endinterface

// File: rtl/systolic_nxn_sparse.sv
// Output-stationary N x N systolic matrix multiply with zero-operand MAC gating
// and a saturating count of gated MACs per tile.
module systolic_nxn_sparse #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int AW = 20,
   parameter int CW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_nxn_sparse_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   localparam int CNTW = $clog2(2*N);
   localparam int PW   = $clog2(N*N+1);

   state_t            state_reg, state_next;
   logic [CNTW-1:0]   cnt_reg, cnt_next;
   logic              ready_w;
   logic              accept;
   logic              clear;

   logic [DW-1:0]     a_west  [N];
   logic              t_west  [N];
   logic [DW-1:0]     b_north [N];
   logic [DW-1:0]     a_east  [N][N-1];
   logic              t_east  [N][N-1];
   logic [DW-1:0]     b_south [N-1][N];
   logic [AW-1:0]     acc_reg [N][N];
   logic [N*N-1:0]    skip_vec;
   logic [PW-1:0]     pop;
   logic [CW:0]       skip_sum;
   logic [CW-1:0]     skip_reg;
   logic [N*N*AW-1:0] c_flat_w;

   assign ready_w = ((state_reg == IDLE) || (state_reg == LOAD)) && !rst;
   assign accept  = bus.in_valid & ready_w;
   // Accumulators and the skip count restart with the first beat of a tile.
   assign clear   = accept && (state_reg == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = bus.in_last ? DRAIN : LOAD;
               cnt_next   = '0;
            end
         end
         LOAD: begin
            if (accept && bus.in_last) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end
         end
         DRAIN: begin
            // The last beat reaches PE(N-1,N-1) 2N-1 edges after acceptance.
            if (cnt_reg == CNTW'(2*N-1)) state_next = DONE;
            else                         cnt_next   = cnt_reg + 1'b1;
         end
         DONE: begin
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Input skew: row i of A and column j of B pass through i+1 / j+1 registers.
   for (genvar gi = 0; gi < N; gi++) begin : gen_skew
      logic [DW-1:0] a_sr [gi+1];
      logic          t_sr [gi+1];
      logic [DW-1:0] b_sr [gi+1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s <= gi; s++) begin
               a_sr[s] <= '0;
               t_sr[s] <= 1'b0;
               b_sr[s] <= '0;
            end
         end else begin
            a_sr[0] <= accept ? bus.a_vec[gi*DW +: DW] : '0;
            t_sr[0] <= accept;
            b_sr[0] <= accept ? bus.b_vec[gi*DW +: DW] : '0;
            for (int s = 1; s <= gi; s++) begin
               a_sr[s] <= a_sr[s-1];
               t_sr[s] <= t_sr[s-1];
               b_sr[s] <= b_sr[s-1];
            end
         end
      end

      assign a_west[gi]  = a_sr[gi];
      assign t_west[gi]  = t_sr[gi];
      assign b_north[gi] = b_sr[gi];
   end

   for (genvar gi = 0; gi < N; gi++) begin : gen_row
      for (genvar gj = 0; gj < N; gj++) begin : gen_pe
         logic [DW-1:0]   a_in, b_in;
         logic            t_in;
         logic [2*DW-1:0] prod;

         if (gj == 0) begin : gen_a_edge
            assign a_in = a_west[gi];
            assign t_in = t_west[gi];
         end else begin : gen_a_inner
            assign a_in = a_east[gi][gj-1];
            assign t_in = t_east[gi][gj-1];
         end

         if (gi == 0) begin : gen_b_edge
            assign b_in = b_north[gj];
         end else begin : gen_b_inner
            assign b_in = b_south[gi-1][gj];
         end

         assign prod = a_in * b_in;
         assign skip_vec[gi*N+gj] = t_in & ((a_in == '0) | (b_in == '0));

         always_ff @(posedge clk) begin
            if (rst)                   acc_reg[gi][gj] <= '0;
            else if (clear)            acc_reg[gi][gj] <= '0;
            else if (t_in && !skip_vec[gi*N+gj])
               acc_reg[gi][gj] <= acc_reg[gi][gj] + AW'(prod);
         end

         if (gj < N-1) begin : gen_pass_a
            always_ff @(posedge clk) begin
               if (rst) begin
                  a_east[gi][gj] <= '0;
                  t_east[gi][gj] <= 1'b0;
               end else begin
                  a_east[gi][gj] <= a_in;
                  t_east[gi][gj] <= t_in;
               end
            end
         end

         if (gi < N-1) begin : gen_pass_b
            always_ff @(posedge clk) begin
               if (rst) b_south[gi][gj] <= '0;
               else     b_south[gi][gj] <= b_in;
            end
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int p = 0; p < N*N; p++) pop = pop + PW'(skip_vec[p]);
   end

   assign skip_sum = {1'b0, skip_reg} + (CW+1)'(pop);

   always_ff @(posedge clk) begin
      if (rst)               skip_reg <= '0;
      else if (clear)        skip_reg <= '0;
      else if (skip_sum[CW]) skip_reg <= '1;
      else                   skip_reg <= skip_sum[CW-1:0];
   end

   always_comb begin
      c_flat_w = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            c_flat_w[(i*N+j)*AW +: AW] = acc_reg[i][j];
   end

   assign bus.in_ready  = ready_w;
   assign bus.out_valid = (state_reg == DONE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.c_flat    = c_flat_w;
   assign bus.skip_cnt  = skip_reg;
endmodule

// File: doc/systolic_nxn_sparse.md
Name: systolic_nxn_sparse

Overview:
Parametrised N x N output-stationary systolic matrix-multiply tile with per-PE zero-operand MAC gating.
- Streams K operand beats (column k of A, row k of B).
- Skews the beats internally and propagates operands right and down through the PE grid.
- Accumulates C = A·B, then presents the full result under a valid/ready handshake.
- Counts gated (skipped) MACs for power/sparsity statistics.
- Successor to the fixed 2x2 sparse array; sits between the operand buffers and the result writeback.

Parameters:
N, 4, array dimension (rows = cols = N), N >= 2
DW, 8, unsigned operand width
AW, 20, accumulator/result width (exact for K <= 16 at DW=8)
CW, 16, skip counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat
in_last  in  1  beat is the final k of the tile
a_vec  in  N*DW  a_vec[i*DW +: DW] = A[i][k]
b_vec  in  N*DW  b_vec[j*DW +: DW] = B[k][j]
out_valid  out  1  result tile valid
out_ready  in  1  consumer takes the result
c_flat  out  N*N*AW  c_flat[(i*N+j)*AW +: AW] = C[i][j]
skip_cnt  out  CW  valid operand pairs with a zero operand in the current or last tile
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - state = IDLE; all accumulators, c_flat and skip_cnt = 0.
  - All skew and pipeline registers, including valid tags, = 0.
  - out_valid = 0, busy = 0.
  - in_ready = 0 while rst = 1, and 1 in the first cycle after rst deasserts.
- A beat is accepted when in_valid & in_ready.
- FSM:
  - IDLE: in_ready = 1. On acceptance, all accumulators and skip_cnt clear on that edge, and the beat enters the pipe. Next state is DRAIN if in_last, else LOAD.
  - LOAD: in_ready = 1. Accepted beats enter the pipe. Acceptance with in_last -> DRAIN. in_valid low inserts a bubble and the state holds.
  - DRAIN: in_ready = 0. A counter runs 2N-1 cycles after the last acceptance edge, then -> DONE.
  - DONE: out_valid = 1, in_ready = 0. c_flat and skip_cnt are held stable. out_valid & out_ready -> IDLE on that edge (out_valid falls).
- Dataflow:
  - Row i of A is delayed i cycles before column 0.
  - Column j of B is delayed j cycles before row 0.
  - Each PE registers its a operand to the right and its b operand downward.
  - A per-beat valid tag travels with the operands, so bubbles stay aligned.
- MAC rule: for a beat accepted at edge e, PE(i,j) updates at edge e+i+j+1.
  - If tag = 1 and a != 0 and b != 0: acc <= acc + a*b (product 2*DW bits, zero-extended, sum modulo 2^AW).
  - If tag = 1 and either operand is 0: acc is held (gated) and the skip event is counted.
  - If tag = 0: no update, no count.
- skip_cnt:
  - Adds the number of skip events per cycle; up to N*N are possible simultaneously.
  - Saturates at 2^CW-1.
- Latency: out_valid is first high in the cycle after edge e_last+2N, where e_last is the acceptance edge of the in_last beat. For N=2 that is 4 cycles.
- c_flat is the registered accumulator array and is valid only while out_valid = 1.
- Boundary conditions:
  - K = 1 (in_last on the first beat) is legal.
  - in_valid while in_ready = 0 is ignored; no state change.
  - in_last is ignored unless in_valid & in_ready.
  - rst during any state aborts the tile and restores all reset values on that edge.
  - out_ready may be held high permanently; DONE then lasts exactly 1 cycle.

Test Plan:
1. N=2, one beat: a=(3,5), b=(7,0), in_last=1 -> C00=21, C01=0, C10=35, C11=0; skip_cnt=2; out_valid rises 4 cycles after acceptance.
2. N=4, K=4: A = identity, B row k = (4k+1 .. 4k+4), back-to-back beats -> C = B (values 1..16), skip_cnt=48, out_valid 8 cycles after the last beat.
3. N=2, K=3 with 2 idle cycles between beats: a=(1,2), (3,4), (5,6) and b=(1,1) each beat -> C00=C01=9, C10=C11=12; result identical to the back-to-back run.
4. Hold out_ready=0 for 5 cycles in DONE -> c_flat and skip_cnt stable, out_valid=1, in_ready=0, and a driven beat is ignored. Raise out_ready -> IDLE next cycle.
5. N=2, AW=20, K=17 beats of all 255s -> every C = 17*65025 mod 2^20 = 56849, skip_cnt=0.
6. Assert rst for 1 cycle during LOAD after 2 beats -> outputs zero, state IDLE. A following one-beat tile a=(2,2), b=(3,3) -> all C=6, no residue from the aborted tile.
